// File: rtl/fifo_wr_arb.sv
// Write-port arbiter: shares one FIFO write port among N_REQ producers.
// Round-robin by default; define FIFO_WR_ARB_FIXED_PRIO_EN for fixed lowest-index priority.
module fifo_wr_arb #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic                    fifo_full,
  input  logic                    fifo_wr_ack,
  input  logic                    fifo_wr_err,
  output logic                    fifo_wr_en,
  output logic [DATA_W-1:0]       fifo_d_in,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        done,
  output logic                    busy,
  output logic [7:0]              err_cnt
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

  logic [1:0]        state_q, state_d;
  logic [IDX_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        err_cnt_q, err_cnt_d;
  logic [N_REQ-1:0]  done_q, done_d;
  logic [IDX_W-1:0]  win_s;
  logic              found_s;
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
  logic [IDX_W-1:0]  ptr_q, ptr_d;
`endif

  // Winner search: first asserted request at or after the scan start, wrapping.
  always_comb begin
    int idx;
    win_s   = {IDX_W{1'b0}};
    found_s = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
`ifdef FIFO_WR_ARB_FIXED_PRIO_EN
      idx = i;
`else
      idx = (int'(ptr_q) + i) % N_REQ;
`endif
      if (!found_s && req[idx]) begin
        found_s = 1'b1;
        win_s   = IDX_W'(idx);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state logic for the issue/wait handshake and bookkeeping.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    data_d    = data_q;
    err_cnt_d = err_cnt_q;
    done_d    = {N_REQ{1'b0}};
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
    ptr_d     = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (!fifo_full && found_s) begin
          sel_d   = win_s;
          data_d  = req_data[int'(win_s)*DATA_W +: DATA_W];
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        state_d = ST_IDLE;
        if (fifo_wr_ack) begin
          done_d = onehot(sel_q);
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
          // Winner drops to lowest priority after an accepted word.
          if (int'(sel_q) == N_REQ - 1) begin
            ptr_d = {IDX_W{1'b0}};
          end else begin
            ptr_d = sel_q + {{(IDX_W-1){1'b0}}, 1'b1};
          end
`endif
        end else if (err_cnt_q != 8'd255) begin
          err_cnt_d = err_cnt_q + 8'd1;
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= {IDX_W{1'b0}};
      data_q    <= {DATA_W{1'b0}};
      err_cnt_q <= 8'd0;
      done_q    <= {N_REQ{1'b0}};
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
      ptr_q     <= {IDX_W{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
      err_cnt_q <= err_cnt_d;
      done_q    <= done_d;
`ifndef FIFO_WR_ARB_FIXED_PRIO_EN
      ptr_q     <= ptr_d;
`endif
    end
  end

  assign fifo_wr_en = (state_q == ST_ISSUE);
  assign fifo_d_in  = (state_q == ST_ISSUE) ? data_q : {DATA_W{1'b0}};
  assign gnt        = ((state_q == ST_ISSUE) || (state_q == ST_WAIT)) ? onehot(sel_q) : {N_REQ{1'b0}};
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;
  assign err_cnt    = err_cnt_q;

endmodule
